// File: rtl/sample_tx_scheduler.sv
// Circular sample buffer sequencer: sensor writes in, bursts drained to the radio
// over one shared single-port memory. Writes always win the port.
module sample_tx_scheduler #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int BATCH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sensor_valid,
    input  logic [DATA_W-1:0] sensor_data,
    input  logic              flush,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic [DATA_W-1:0] mem_data_out,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write,
    output logic              mem_read,
    input  logic              radio_busy,
    output logic              radio_send,
    output logic [DATA_W-1:0] radio_data_out,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, SEND, GAP} state_t;

    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   BATCH_C  = (ADDR_W+1)'(BATCH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH-1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   burst_q, burst_d;
    logic [DATA_W-1:0] mem_data_out_q, mem_data_out_d;
    logic [DATA_W-1:0] radio_data_q, radio_data_d;
    logic              mem_write_q, mem_write_d;
    logic              mem_read_q, mem_read_d;
    logic              radio_send_q, radio_send_d;
    logic              overflow_q, overflow_d;
    logic              accept;
    logic              capture;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_ONE;
    endfunction

    always_comb begin
        accept         = sensor_valid && (count_q < DEPTH_C);
        capture        = (state_q == RD_WAIT);
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        mem_address_d  = mem_address_q;
        mem_data_out_d = mem_data_out_q;
        radio_data_d   = radio_data_q;
        burst_d        = burst_q;
        mem_write_d    = 1'b0;
        mem_read_d     = 1'b0;
        radio_send_d   = 1'b0;
        overflow_d     = overflow_q | (sensor_valid && (count_q == DEPTH_C));

        if (accept) begin
            mem_write_d    = 1'b1;
            mem_address_d  = wr_ptr_q;
            mem_data_out_d = sensor_data;
            wr_ptr_d       = ptr_inc(wr_ptr_q);
        end

        case ({accept, capture})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if ((count_q >= BATCH_C) || (flush && (count_q != '0))) begin
                    burst_d = (count_q > BATCH_C) ? BATCH_C : count_q;
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                // A write accepted this edge owns the port; retry next edge.
                if (!accept) begin
                    mem_read_d    = 1'b1;
                    mem_address_d = rd_ptr_q;
                    state_d       = RD_WAIT;
                end
            end
            RD_WAIT: begin
                radio_data_d = mem_data_in;
                rd_ptr_d     = ptr_inc(rd_ptr_q);
                burst_d      = burst_q - CNT_ONE;
                state_d      = SEND;
            end
            SEND: begin
                if (!radio_busy) begin
                    radio_send_d = 1'b1;
                    state_d      = GAP;
                end
            end
            GAP: begin
                state_d = ((burst_q != '0) && (count_q != '0)) ? RD_REQ : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            mem_address_q  <= '0;
            mem_data_out_q <= '0;
            radio_data_q   <= '0;
            count_q        <= '0;
            burst_q        <= '0;
            mem_write_q    <= 1'b0;
            mem_read_q     <= 1'b0;
            radio_send_q   <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            mem_address_q  <= mem_address_d;
            mem_data_out_q <= mem_data_out_d;
            radio_data_q   <= radio_data_d;
            count_q        <= count_d;
            burst_q        <= burst_d;
            mem_write_q    <= mem_write_d;
            mem_read_q     <= mem_read_d;
            radio_send_q   <= radio_send_d;
            overflow_q     <= overflow_d;
        end
    end

    assign mem_data_out   = mem_data_out_q;
    assign mem_address    = mem_address_q;
    assign mem_write      = mem_write_q;
    assign mem_read       = mem_read_q;
    assign radio_send     = radio_send_q;
    assign radio_data_out = radio_data_q;
    assign count          = count_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_sample_tx_scheduler.sv
// Directed bench: default-sized instance A for burst/flush/arbitration/backpressure/reset,
// small instance B (DEPTH=8, BATCH=8) for overflow and pointer wrap.
module tb_sample_tx_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // instance A
    logic       rst_a, sv_a, fl_a, rb_a;
    logic [7:0] sd_a, mdi_a, mdo_a, ma_a, rdo_a;
    logic       mw_a, mr_a, rs_a, ov_a;
    logic [8:0] cnt_a;
    // instance B
    logic       rst_b, sv_b, fl_b, rb_b;
    logic [7:0] sd_b, mdi_b, mdo_b, rdo_b;
    logic [2:0] ma_b;
    logic       mw_b, mr_b, rs_b, ov_b;
    logic [3:0] cnt_b;

    sample_tx_scheduler dut_a (
        .clk(clk), .rst(rst_a), .sensor_valid(sv_a), .sensor_data(sd_a), .flush(fl_a),
        .mem_data_in(mdi_a), .mem_data_out(mdo_a), .mem_address(ma_a), .mem_write(mw_a),
        .mem_read(mr_a), .radio_busy(rb_a), .radio_send(rs_a), .radio_data_out(rdo_a),
        .count(cnt_a), .overflow(ov_a)
    );

    sample_tx_scheduler #(.ADDR_W(3), .DATA_W(8), .DEPTH(8), .BATCH(8)) dut_b (
        .clk(clk), .rst(rst_b), .sensor_valid(sv_b), .sensor_data(sd_b), .flush(fl_b),
        .mem_data_in(mdi_b), .mem_data_out(mdo_b), .mem_address(ma_b), .mem_write(mw_b),
        .mem_read(mr_b), .radio_busy(rb_b), .radio_send(rs_b), .radio_data_out(rdo_b),
        .count(cnt_b), .overflow(ov_b)
    );

    // memory models: write on the clock, read data follows the presented address
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [8];
    always @(posedge clk) if (mw_a) mem_a[ma_a] <= mdo_a;
    always @(posedge clk) if (mw_b) mem_b[ma_b] <= mdo_b;
    assign mdi_a = mem_a[ma_a];
    assign mdi_b = mem_b[ma_b];

    logic [7:0] sa[$], wa_addr[$], wa_data[$], ra_addr[$], sb[$];
    logic [2:0] wb_addr[$], rb_addr[$];
    int         sa_t[$];
    int         both_a = 0, both_b = 0;

    always @(negedge clk) begin
        if (mw_a) begin wa_addr.push_back(ma_a); wa_data.push_back(mdo_a); end
        if (mr_a) ra_addr.push_back(ma_a);
        if (rs_a) begin sa.push_back(rdo_a); sa_t.push_back(cyc); end
        if (mw_a && mr_a) both_a <= both_a + 1;
        if (mw_b) wb_addr.push_back(ma_b);
        if (mr_b) rb_addr.push_back(ma_b);
        if (rs_b) sb.push_back(rdo_b);
        if (mw_b && mr_b) both_b <= both_b + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic put_a(input logic [7:0] d);
        sv_a = 1'b1; sd_a = d;
        @(negedge clk);
        sv_a = 1'b0;
    endtask

    task automatic put_b(input logic [7:0] d);
        sv_b = 1'b1; sd_b = d;
        @(negedge clk);
        sv_b = 1'b0;
    endtask

    task automatic wait_sends_a(input int n, input string tag);
        int k = 0;
        while (sa.size() < n && k < 300) begin @(negedge clk); k++; end
        chk(tag, 32'(sa.size()), 32'(n));
    endtask

    task automatic wait_sends_b(input int n, input string tag);
        int k = 0;
        while (sb.size() < n && k < 600) begin @(negedge clk); k++; end
        chk(tag, 32'(sb.size()), 32'(n));
    endtask

    task automatic clear_a();
        sa.delete(); sa_t.delete(); wa_addr.delete(); wa_data.delete(); ra_addr.delete();
    endtask

    initial begin
        int k;
        rst_a = 1'b1; sv_a = 1'b0; sd_a = '0; fl_a = 1'b0; rb_a = 1'b0;
        rst_b = 1'b1; sv_b = 1'b0; sd_b = '0; fl_b = 1'b0; rb_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_a_ctrl", 32'({mw_a, mr_a, rs_a, ov_a}), 0);
        chk("rst_a_addr", 32'(ma_a), 0);
        chk("rst_a_data", 32'({mdo_a, rdo_a}), 0);
        chk("rst_a_cnt", 32'(cnt_a), 0);
        chk("rst_b_all", 32'({mw_b, mr_b, rs_b, ov_b, ma_b, cnt_b}), 0);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        // basic burst
        for (int i = 0; i < 4; i++) put_a(8'(8'h11 + i));
        k = 0;
        while (!rs_a && k < 50) begin @(negedge clk); k++; end
        chk("t1_first_send_lat", 32'(k), 4);
        wait_sends_a(4, "t1_nsend");
        repeat (4) @(negedge clk);
        chk("t1_nwrite", 32'(wa_addr.size()), 4);
        chk("t1_nread", 32'(ra_addr.size()), 4);
        if (wa_addr.size() >= 4 && ra_addr.size() >= 4 && sa.size() >= 4)
            for (int i = 0; i < 4; i++) begin
                chk("t1_waddr", 32'(wa_addr[i]), 32'(i));
                chk("t1_raddr", 32'(ra_addr[i]), 32'(i));
                chk("t1_data", 32'(sa[i]), 32'(8'h11 + i));
            end
        if (sa_t.size() >= 2) chk("t1_spacing", 32'(sa_t[1] - sa_t[0]), 4);
        chk("t1_cnt", 32'(cnt_a), 0);
        clear_a();

        // flush below batch
        put_a(8'hA0);
        put_a(8'hA1);
        repeat (10) @(negedge clk);
        chk("t2_nosend", 32'(sa.size()), 0);
        chk("t2_cnt_hold", 32'(cnt_a), 2);
        fl_a = 1'b1;
        wait_sends_a(2, "t2_nsend");
        repeat (10) @(negedge clk);
        fl_a = 1'b0;
        chk("t2_exact", 32'(sa.size()), 2);
        if (sa.size() >= 2) begin
            chk("t2_d0", 32'(sa[0]), 32'h A0);
            chk("t2_d1", 32'(sa[1]), 32'h A1);
        end
        if (wa_addr.size() >= 1) chk("t2_waddr", 32'(wa_addr[0]), 4);
        chk("t2_cnt", 32'(cnt_a), 0);
        clear_a();

        // arbitration: write lands on the edge the FSM sits in RD_REQ
        for (int i = 0; i < 4; i++) put_a(8'(8'hB0 + i));
        @(negedge clk);
        put_a(8'hC0);
        chk("t3_write_wins", 32'({mw_a, mr_a}), 32'b10);
        chk("t3_waddr", 32'(ma_a), 10);
        @(negedge clk);
        chk("t3_read_next", 32'({mw_a, mr_a}), 32'b01);
        chk("t3_raddr", 32'(ma_a), 6);
        wait_sends_a(4, "t3_nsend");
        fl_a = 1'b1;
        wait_sends_a(5, "t3_flush_send");
        fl_a = 1'b0;
        if (sa.size() >= 5) begin
            for (int i = 0; i < 4; i++) chk("t3_data", 32'(sa[i]), 32'(8'hB0 + i));
            chk("t3_late_data", 32'(sa[4]), 32'h C0);
        end
        chk("t3_cnt", 32'(cnt_a), 0);
        clear_a();

        // radio backpressure
        rb_a = 1'b1;
        for (int i = 0; i < 4; i++) put_a(8'(8'hD0 + i));
        repeat (6) @(negedge clk);
        chk("t4_cnt", 32'(cnt_a), 3);
        chk("t4_captured", 32'(rdo_a), 32'h D0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_nosend", 32'(rs_a), 0);
            chk("t4_stable", 32'(rdo_a), 32'h D0);
        end
        rb_a = 1'b0;
        wait_sends_a(4, "t4_nsend");
        repeat (4) @(negedge clk);
        if (sa.size() >= 4)
            for (int i = 0; i < 4; i++) chk("t4_data", 32'(sa[i]), 32'(8'hD0 + i));
        chk("t4_cnt_end", 32'(cnt_a), 0);
        clear_a();

        // reset during RD_WAIT
        for (int i = 0; i < 4; i++) put_a(8'(8'hE0 + i));
        repeat (2) @(negedge clk);
        chk("t5_in_rd_wait", 32'(mr_a), 1);
        rst_a = 1'b1;
        @(negedge clk);
        chk("t5_rst_ctrl", 32'({mw_a, mr_a, rs_a, ov_a}), 0);
        chk("t5_rst_addr", 32'(ma_a), 0);
        chk("t5_rst_data", 32'({mdo_a, rdo_a}), 0);
        chk("t5_rst_cnt", 32'(cnt_a), 0);
        rst_a = 1'b0;
        put_a(8'hF0);
        chk("t5_new_write", 32'({mw_a, ma_a, mdo_a}), 32'({1'b1, 8'h00, 8'hF0}));
        chk("t5_new_cnt", 32'(cnt_a), 1);

        // overflow and wrap on the small instance
        rb_b = 1'b1;
        for (int i = 0; i < 9; i++) put_b(8'(8'h30 + i));
        chk("t6_cnt_full", 32'(cnt_b), 8);
        chk("t6_overflow", 32'(ov_b), 1);
        chk("t6_nwrite", 32'(wb_addr.size()), 8);
        if (wb_addr.size() >= 8) chk("t6_last_waddr", 32'(wb_addr[7]), 7);
        repeat (5) @(negedge clk);
        chk("t6_cnt_after_cap", 32'(cnt_b), 7);
        rb_b = 1'b0;
        wait_sends_b(8, "t6_nsend1");
        for (int i = 0; i < 8; i++) put_b(8'(8'h40 + i));
        wait_sends_b(16, "t6_nsend2");
        repeat (10) @(negedge clk);
        chk("t6_exact", 32'(sb.size()), 16);
        if (wb_addr.size() >= 16) begin
            chk("t6_wrap_w0", 32'(wb_addr[8]), 0);
            chk("t6_wrap_w7", 32'(wb_addr[15]), 7);
        end
        if (rb_addr.size() >= 9) chk("t6_wrap_r", 32'(rb_addr[8]), 0);
        if (sb.size() >= 16)
            for (int i = 0; i < 8; i++) begin
                chk("t6_data1", 32'(sb[i]), 32'(8'h30 + i));
                chk("t6_data2", 32'(sb[i+8]), 32'(8'h40 + i));
            end
        chk("t6_ov_sticky", 32'(ov_b), 1);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        chk("t6_ov_clear", 32'({ov_b, cnt_b}), 0);

        chk("both_a", 32'(both_a), 0);
        chk("both_b", 32'(both_b), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
